// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the LEGv8 multi-cycle control FSM and opcode classifier.
// TRAP exists only when LEGV8_CTRL_ILLEGAL_TRAP_EN is defined.
package legv8_ctrl_pkg;

    localparam int OPC_W = 11;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB       = 4'd8,
        BRANCH   = 4'd9
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
        ,
        TRAP     = 4'd10
`endif
    } state_e;

    typedef enum logic [2:0] {
        CLS_OTHER = 3'd0,
        CLS_R     = 3'd1,
        CLS_I     = 3'd2,
        CLS_LD    = 3'd3,
        CLS_ST    = 3'd4,
        CLS_CBZ   = 3'd5,
        CLS_B     = 3'd6
    } opc_class_e;

    localparam logic [OPC_W-1:0] OPC_ADD  = 11'b10001011000;
    localparam logic [OPC_W-1:0] OPC_SUB  = 11'b11001011000;
    localparam logic [OPC_W-1:0] OPC_AND  = 11'b10001010000;
    localparam logic [OPC_W-1:0] OPC_ORR  = 11'b10101010000;
    localparam logic [OPC_W-1:0] OPC_ADDI = 11'b10010001000;
    localparam logic [OPC_W-1:0] OPC_SUBI = 11'b11010001000;
    localparam logic [OPC_W-1:0] MASK_I   = 11'b11111111110;
    localparam logic [OPC_W-1:0] OPC_LDUR = 11'b11111000010;
    localparam logic [OPC_W-1:0] OPC_STUR = 11'b11111000000;
    localparam logic [OPC_W-1:0] OPC_CBZ  = 11'b10110100000;
    localparam logic [OPC_W-1:0] MASK_CBZ = 11'b11111111000;
    localparam logic [OPC_W-1:0] OPC_B    = 11'b00010100000;
    localparam logic [OPC_W-1:0] MASK_B   = 11'b11111100000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASSB = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] EXT_I  = 2'b00;
    localparam logic [1:0] EXT_D  = 2'b01;
    localparam logic [1:0] EXT_B  = 2'b10;
    localparam logic [1:0] EXT_CB = 2'b11;

    function automatic logic [1:0] ext_sel_for(input opc_class_e cls);
        case (cls)
            CLS_LD, CLS_ST: ext_sel_for = EXT_D;
            CLS_B:          ext_sel_for = EXT_B;
            CLS_CBZ:        ext_sel_for = EXT_CB;
            default:        ext_sel_for = EXT_I;
        endcase
    endfunction

endpackage

// File: rtl/legv8_opcode_classifier.sv
// Combinational LEGv8 opcode -> instruction class decode.
// Kept standalone so the pipelined decoder can reuse it.
module legv8_opcode_classifier
    import legv8_ctrl_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    output opc_class_e       cls
);

    always_comb begin
        cls = CLS_OTHER;
        if (opcode == OPC_ADD || opcode == OPC_SUB ||
            opcode == OPC_AND || opcode == OPC_ORR)
            cls = CLS_R;
        else if ((opcode & MASK_I) == OPC_ADDI || (opcode & MASK_I) == OPC_SUBI)
            cls = CLS_I;
        else if (opcode == OPC_LDUR)
            cls = CLS_LD;
        else if (opcode == OPC_STUR)
            cls = CLS_ST;
        else if ((opcode & MASK_CBZ) == OPC_CBZ)
            cls = CLS_CBZ;
        else if ((opcode & MASK_B) == OPC_B)
            cls = CLS_B;
    end

endmodule

// File: rtl/legv8_multicycle_control.sv
// Multi-cycle LEGv8 control FSM with a single memory-ready handshake.
// Define LEGV8_CTRL_ILLEGAL_TRAP_EN to trap unknown opcodes; otherwise they retire as NOPs.
//
// state    | meaning
// IDLE     | one cycle after reset release
// FETCH    | instruction read, waits for mem_ready, latches opcode class
// DECODE   | branch on latched class
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// MEM_ADDR | LDUR/STUR address calculation
// MEM_RD   | data read, waits for mem_ready
// MEM_WR   | data write, waits for mem_ready
// WB       | register write-back
// BRANCH   | B / CBZ resolution
// TRAP     | unknown opcode, held until reset (trap build only)
module legv8_multicycle_control
    import legv8_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPC_W-1:0] opcode,
    input  logic             mem_ready,
    input  logic             alu_zero,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       ext_sel,
    output logic             illegal,
    output logic [3:0]       state_o
);

    state_e     state_q, state_nxt;
    opc_class_e cls_q, cls_nxt, cls_in;
    logic       taken;

    legv8_opcode_classifier u_classifier (
        .opcode (opcode),
        .cls    (cls_in)
    );

    always_comb begin
        state_nxt = state_q;
        cls_nxt   = cls_q;
        case (state_q)
            IDLE:   state_nxt = FETCH;
            FETCH: begin
                if (mem_ready) begin
                    state_nxt = DECODE;
                    cls_nxt   = cls_in;
                end
            end
            DECODE: begin
                case (cls_q)
                    CLS_R:          state_nxt = EXEC_R;
                    CLS_I:          state_nxt = EXEC_I;
                    CLS_LD, CLS_ST: state_nxt = MEM_ADDR;
                    CLS_CBZ, CLS_B: state_nxt = BRANCH;
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
                    default:        state_nxt = TRAP;
`else
                    default:        state_nxt = FETCH;
`endif
                endcase
            end
            EXEC_R, EXEC_I: state_nxt = WB;
            MEM_ADDR: state_nxt = (cls_q == CLS_LD) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_nxt = WB;
            MEM_WR:   if (mem_ready) state_nxt = FETCH;
            WB, BRANCH: state_nxt = FETCH;
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
            TRAP:     state_nxt = TRAP;
`endif
            default:  state_nxt = IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cls_q      <= CLS_OTHER;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            reg_write  <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_src_b  <= 1'b0;
            alu_op     <= ALU_ADD;
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
            illegal    <= 1'b0;
`endif
        end else begin
            state_q    <= state_nxt;
            cls_q      <= cls_nxt;
            mem_read   <= (state_nxt == FETCH) || (state_nxt == MEM_RD);
            mem_write  <= (state_nxt == MEM_WR);
            reg_write  <= (state_nxt == WB);
            mem_to_reg <= (state_nxt == WB) && (cls_nxt == CLS_LD);
            alu_src_b  <= (state_nxt == EXEC_I) || (state_nxt == MEM_ADDR);
            if (state_nxt == EXEC_R || state_nxt == EXEC_I)
                alu_op <= ALU_FUNCT;
            else if (state_nxt == BRANCH && cls_nxt == CLS_CBZ)
                alu_op <= ALU_PASSB;
            else
                alu_op <= ALU_ADD;
`ifdef LEGV8_CTRL_ILLEGAL_TRAP_EN
            illegal    <= (state_nxt == TRAP);
`endif
        end
    end

`ifndef LEGV8_CTRL_ILLEGAL_TRAP_EN
    assign illegal = 1'b0;
`endif

    // Handshake-qualified strobes; state_q is IDLE under reset so these clear at once.
    assign taken    = (state_q == BRANCH) &&
                      ((cls_q == CLS_B) || (cls_q == CLS_CBZ && alu_zero));
    assign ir_write = (state_q == FETCH) && mem_ready;
    assign pc_write = ir_write || taken;
    assign pc_src   = taken;
    assign ext_sel  = ext_sel_for(cls_q);
    assign state_o  = state_q;

endmodule
